// File: rtl/countdown_pkg.sv
// Shared types and defaults for the minute countdown timer.
package countdown_pkg;

    localparam int DEFAULT_MAX_MINUTES = 99;
    localparam int DEFAULT_MIN_W       = 7;
    localparam int BCD_W               = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/min_to_bcd.sv
// Combinational minute count to two BCD digits; valid for values 0..99,
// which the controller guarantees by saturating every load.
module min_to_bcd
    import countdown_pkg::*;
#(
    parameter int MIN_W = DEFAULT_MIN_W
) (
    input  logic [MIN_W-1:0] value,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    assign tens = BCD_W'(value / MIN_W'(10));
    assign ones = BCD_W'(value % MIN_W'(10));

endmodule

// File: rtl/countdown_controller.sv
// Countdown sequencing FSM: owns the remaining-minutes register, decodes
// user commands, gates the minute divider and raises the expiry alarm.
module countdown_controller
    import countdown_pkg::*;
#(
    parameter int MAX_MINUTES = DEFAULT_MAX_MINUTES,
    parameter int MIN_W       = DEFAULT_MIN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [MIN_W-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic             div_hold,
    output logic [MIN_W-1:0] remaining,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             running,
    output logic             alarm
);

    localparam logic [MIN_W-1:0] MAX_VAL = MIN_W'(MAX_MINUTES);

    state_t           state;
    state_t           state_n;
    logic [MIN_W-1:0] remaining_n;
    logic [MIN_W-1:0] load_sat;
    logic [BCD_W-1:0] tens_n;
    logic [BCD_W-1:0] ones_n;
    logic             tick_ok;

    assign load_sat = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    // A tick seen while the divider is held is a divider artefact.
    assign tick_ok = tick && !div_hold;

    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        state_n     = state;
        remaining_n = remaining;
        if (clear) begin
            state_n     = ST_IDLE;
            remaining_n = '0;
        end else begin
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (load) begin
                        remaining_n = load_sat;
                    end else if (start && remaining != '0) begin
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Ignored load/start never swallow a tick; a coincident
                    // pause takes effect after the tick, and expiry wins.
                    if (tick_ok) begin
                        if (remaining > MIN_W'(1)) begin
                            remaining_n = remaining - MIN_W'(1);
                        end else begin
                            remaining_n = '0;
                            state_n     = ST_EXPIRED;
                        end
                    end
                    if (pause && state_n == ST_RUN) begin
                        state_n = ST_PAUSE;
                    end
                end
                default: ;
            endcase
        end
    end

    min_to_bcd #(.MIN_W(MIN_W)) u_bcd (
        .value (remaining_n),
        .tens  (tens_n),
        .ones  (ones_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            tens      <= '0;
            ones      <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            div_hold  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state     <= state_n;
            remaining <= remaining_n;
            tens      <= tens_n;
            ones      <= ones_n;
            running   <= (state_n == ST_RUN);
            alarm     <= (state_n == ST_EXPIRED);
            div_hold  <= (state_n != ST_RUN);
        end
    end

endmodule
